// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, flag vector layout, FSM encoding.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_MOVI = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    // Packed flag vector layout {C,L,F,Z,N}
    localparam int FLG_N     = 0;
    localparam int FLG_Z     = 1;
    localparam int FLG_F     = 2;
    localparam int FLG_L     = 3;
    localparam int FLG_C     = 4;
    localparam int NUM_FLAGS = 5;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/completion bundle between the controller and the sequential ALU.
interface alu_seq_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluControl;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             C;
    logic             L;
    logic             F;
    logic             Z;
    logic             N;

    modport master (
        output in_valid, a, b, aluControl,
        input  in_ready, out_valid, result, busy, C, L, F, Z, N
    );

    modport slave (
        input  in_valid, a, b, aluControl,
        output in_ready, out_valid, result, busy, C, L, F, Z, N
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one partial product per cycle; done/products are valid on the final step's edge.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) acc_nxt = acc + mcand;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    // Products come from acc_nxt so the caller can register them on the same edge the count hits zero.
    assign done       = (cnt == CW'(1));
    assign prod_lo    = acc_nxt[WIDTH-1:0];
    assign prod_hi_nz = |acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready issue, flag register and optional iterative multiply.
// state   | meaning
// ST_IDLE | accepting ops; single-cycle ops complete on the accept edge
// ST_MUL  | multiply in progress, issue stalled until the last step
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic             mul_hi_nz;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    flags_t           flg_d;
    flags_t           flg_q;
    logic             vld_q;

    assign is_mul = MUL_EN && (bus.aluControl == OP_MUL);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)         state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_MUL);
        ready     = (state == ST_IDLE);
        mul_start = accept && is_mul;
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk        (clk),
                .reset      (reset),
                .start      (mul_start),
                .a          (bus.a),
                .b          (bus.b),
                .done       (mul_done),
                .prod_lo    (mul_lo),
                .prod_hi_nz (mul_hi_nz)
            );
        end else begin : g_nomul
            assign mul_done  = 1'b0;
            assign mul_lo    = '0;
            assign mul_hi_nz = 1'b0;
        end
    endgenerate

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = bus.a - bus.b;

    // Single-cycle datapath; anything not decoded here (incl. MUL when not built) yields 0 and holds flags.
    always_comb begin
        res_d = '0;
        flg_d = flg_q;
        case (bus.aluControl)
            OP_SUB: begin
                res_d        = diff;
                flg_d[FLG_C] = bus.a < bus.b;
                flg_d[FLG_F] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_CMP: begin
                flg_d[FLG_L] = bus.a < bus.b;
                flg_d[FLG_N] = $signed(bus.a) < $signed(bus.b);
                flg_d[FLG_Z] = bus.a == bus.b;
            end
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_XOR:  res_d = bus.a ^ bus.b;
            OP_MOV:  res_d = bus.b;
            OP_MOVI: res_d = bus.a;
            OP_ADD: begin
                res_d        = sum[WIDTH-1:0];
                flg_d[FLG_C] = sum[WIDTH];
                flg_d[FLG_F] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
            flg_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (state == ST_MUL && mul_done) begin
                res_q        <= mul_lo;
                flg_q[FLG_C] <= mul_hi_nz;
                vld_q        <= 1'b1;
            end else if (accept && !is_mul) begin
                res_q <= res_d;
                flg_q <= flg_d;
                vld_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = busy;
    assign bus.out_valid = vld_q;
    assign bus.result    = res_q;
    assign bus.C         = flg_q[FLG_C];
    assign bus.L         = flg_q[FLG_L];
    assign bus.F         = flg_q[FLG_F];
    assign bus.Z         = flg_q[FLG_Z];
    assign bus.N         = flg_q[FLG_N];

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's combinational 16-bit ALU.
- Keeps the existing 4-bit opcode map and adds an iterative multiply.
- Computes architecturally correct C/F/L/N/Z flags and holds them in a flag register that only flag-defining ops update.
- Sits between the register-file read stage and writeback; the controller handshakes with valid/ready so multi-cycle ops stall issue.

Parameters:
- WIDTH, 16, datapath width in bits; legal range 4..64.
- MUL_EN, 1, 1 builds the iterative multiplier; 0 turns opcode 1001 into an illegal op.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an op; equals ~busy
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- aluControl  in  4  opcode
- out_valid  out  1  one-cycle pulse when result and flags are updated
- result  out  WIDTH  registered result, held until next completion
- busy  out  1  multi-cycle op in progress
- C, L, F, Z, N  out  1 each  registered flags

Behaviour:
- Reset (reset=0, asynchronous): result=0, all flags=0, out_valid=0, busy=0, in_ready=1, FSM=IDLE. Any multiply in flight is discarded.
- Accept: an op is accepted on a rising edge where in_valid && in_ready. While busy, in_valid is ignored; nothing is queued.
- Opcodes:
  - 0000 NOP: result=0.
  - 0001 SUB: a-b.
  - 0010 CMP: result=0.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 MOV: result=b.
  - 0111 MOVI: result=a.
  - 1000 ADD: a+b.
  - 1001 MUL: low WIDTH bits of a*b, unsigned.
  - 1010..1111 illegal: result=0, flags unchanged, out_valid still pulses.
- Arithmetic: all results truncate modulo 2^WIDTH.
- Flag writes (only these ops change flags; every other op holds all flags):
  - ADD writes C=carry out of bit WIDTH-1, F=signed overflow (operands same sign, result sign differs).
  - SUB writes C=borrow (a<b unsigned), F=signed overflow (operand signs differ, result sign differs from a).
  - CMP writes L=(a<b unsigned), N=(a<b signed two's complement), Z=(a==b). All three are written every CMP.
  - MUL writes C=(upper WIDTH bits of full product != 0). F is unchanged.
- Single-cycle ops: the accepting edge registers result and flags; out_valid=1 for the following cycle. Back-to-back ops give 1 op/cycle.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - Accept edge: latch a and b into the sub-module, load counter=WIDTH, busy=1, in_ready=0.
  - Each cycle in MUL performs one shift-add step and decrements the counter.
  - On the edge where the counter reaches 0: register result and C, busy=0, out_valid=1 for one cycle, return to IDLE.
  - Accept at edge 0 gives out_valid in the cycle after edge WIDTH. WIDTH=16 gives 16 cycles of busy.
  - in_ready returns to 1 in the same cycle out_valid is high, so a new op can be accepted then.
- Operand stability: a, b and aluControl only need to be valid on the accept edge; the multiplier uses latched copies.
- Reset during MUL returns immediately to reset state; no out_valid is produced for the aborted op.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 4-bit opcodes (OP_NOP .. OP_MUL);
  - flag bit indices for a packed flag vector {C,L,F,Z,N};
  - the state encoding (IDLE, MUL).
- Sub-module alu_mul_iter(WIDTH) holds the shift-add multiplier.
  - Interface: start, a, b; outputs done, prod_lo, prod_hi_nz.
  - Top level keeps the handshake, the single-cycle datapath and the flag register.

Test Plan:
- ADD a=0xFFFF b=0x0001 -> result=0x0000, C=1, F=0, out_valid one cycle after accept. Then a=0x7FFF b=0x0001 -> result=0x8000, C=0, F=1.
- SUB a=0x0003 b=0x0005 -> result=0xFFFE, C=1, F=0. Then a=0x8000 b=0x0001 -> result=0x7FFF, C=0, F=1.
- CMP a=0x8000 b=0x0001 -> L=0, N=1, Z=0, result=0. Then CMP a=b=0x1234 -> Z=1, L=0, N=0. Then AND 0x00FF&0x0F0F -> result=0x000F with Z=1 still held.
- MUL a=0x0100 b=0x0100 -> busy for 16 cycles, in_ready=0, out_valid in cycle after edge 16, result=0x0000, C=1. Then a=0x0003 b=0x0005 -> result=0x000F, C=0.
- During MUL, drive in_valid with ADD 1+1 every cycle -> not accepted, result unchanged until the MUL completes. Reassert in the out_valid cycle -> accepted; result=0x0002 on the next cycle.
- Assert reset=0 asynchronously at cycle 8 of a MUL -> all outputs 0 immediately, no out_valid after release. Opcode 1100 after release -> result=0, flags unchanged, out_valid pulses.
